rram_xbar_seq: RTL and testbench
================================

Name: rram_xbar_seq

Overview:
- Digital sequencer that produces the Dwl/Dsl/Dbl/Dset control bits consumed by the 4x4 RRAM crossbar cell model.
- Also captures the comparator-digitised sigmoid column outputs returned by that model.
- Accepts single commands: SET-program one row, or run one inference read. Applies the timed pulse/settle sequence, then returns a one-cycle response.
- Sits between the accelerator command bus and the analog crossbar model.

Parameters:
- PULSE_CYC, 8, cycles Dwl held high during a SET pulse (1..255)
- SETTLE_CYC, 4, cycles from read-bias application to sampling sum_bit (1..255; the 2-flop sync delay is included)
- GAP_CYC, 2, all-drives-low recovery cycles after every operation (1..255)
- MAX_RETRY, 3, extra SET pulses allowed under write-verify (0..7)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  1  0 = READ (inference), 1 = SET (program row)
- cmd_row  in  2  target row for SET
- cmd_data  in  4  SET: bitline pattern; READ: wordline input vector
- Dwl  out  4  wordline enables to crossbar
- Dsl  out  4  sourceline enables to crossbar
- Dbl  out  4  bitline enables to crossbar
- Dset  out  1  bitline level select (1 = 2*vdd programming level)
- sum_bit  in  4  comparator outputs (sum > 0.5 V), asynchronous to clk
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  4  READ: sampled column bits; SET: verify readback (zero without the feature)
- rsp_err  out  1  SET verify failed after retries; always 0 for READ
- busy  out  1  state != IDLE

Behaviour:
- Reset values: Dwl = Dsl = Dbl = 0, Dset = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, cmd_ready = 1, busy = 0, state = IDLE, counters = 0.
- Async reset mid-operation forces every drive low immediately, not at the next edge. This is a device-safety requirement.
- All outputs are registered. Dsl = 0 in every state; the sourceline is grounded, and the port exists for future RESET support.
- cmd_ready = (state == IDLE). A command is accepted on a clk edge with cmd_valid & cmd_ready. cmd_row/cmd_data are latched at accept.
- sum_bit passes through a 2-flop synchroniser before use.
- States:
  - IDLE: all drives 0. On accept: op = 1 -> WR_SETUP; op = 0 -> RD_BIAS.
  - WR_SETUP (1 cycle): Dset = 1, Dbl = data, Dwl = 0. The bitline level settles before the wordline opens. Go to WR_PULSE.
  - WR_PULSE (PULSE_CYC cycles): Dset = 1, Dbl = data, Dwl = onehot(row). Then WR_HOLD.
  - WR_HOLD (1 cycle): Dwl = 0, Dset/Dbl still held. The wordline always closes before the bitline drops. Then GAP; without the feature, the response is issued on GAP entry.
  - RD_BIAS (SETTLE_CYC cycles): Dset = 0, Dbl = 4'b1111, Dwl = data. Then RD_SAMPLE.
  - RD_SAMPLE (1 cycle): capture synced sum_bit into rsp_data, pulse rsp_valid, rsp_err = 0. Drives are still held this cycle. Then GAP.
  - GAP (GAP_CYC cycles): all drives 0. Then IDLE.
- Latency, READ: accept edge to rsp_valid = SETTLE_CYC + 1 cycles. Accept-to-accept = SETTLE_CYC + 1 + GAP_CYC + 1.
- Latency, SET (no feature): rsp_valid asserts on the cycle GAP is entered, i.e. PULSE_CYC + 2 cycles after accept.
- Dset never changes in a cycle where Dwl != 0. Dset = 1 never coexists with Dbl = 1111 read bias from a read.
- READ with cmd_data = 0: full sequence still runs; rsp_data is whatever the comparators report (nominally 0).
- rsp_valid is held for exactly 1 cycle; there is no backpressure. cmd_valid while busy is ignored and not queued.

Optional Feature:
- Macro: RRAM_VERIFY_EN
- With the macro, after WR_HOLD the FSM enters VFY_BIAS (SETTLE_CYC cycles): Dset = 0, Dbl = 1111, Dwl = onehot(row). It then enters VFY_CHECK and compares the synced sum_bit with the latched data.
  - Match: rsp_valid, rsp_data = readback, rsp_err = 0, then GAP.
  - Mismatch with retries < MAX_RETRY: GAP_CYC all-low cycles, then WR_SETUP again with retry + 1.
  - Mismatch at MAX_RETRY: rsp_valid, rsp_err = 1, rsp_data = last readback.
  - The retry counter clears on accept.
- Without the macro, the VFY states do not exist and the SET response has rsp_data = 0, rsp_err = 0.

Test Plan:
- Reset asserted mid WR_PULSE (Dwl = 0100, Dset = 1) -> Dwl/Dbl/Dset all 0 before the next clk edge; after release, cmd_ready = 1.
- SET row = 2, data = 1011, defaults -> Dset = 1, Dbl = 1011 one cycle with Dwl = 0; then Dwl = 0100 for exactly 8 cycles; then Dwl = 0 one cycle before Dbl/Dset drop; rsp_valid at cycle 10 after accept; rsp_err = 0.
- READ data = 0110, sum_bit held at 1001 -> Dwl = 0110, Dbl = 1111, Dset = 0 for 4 cycles; rsp_valid at cycle 5 with rsp_data = 1001; then 2 all-low cycles; next accept no earlier than cycle 8.
- Back-to-back: cmd_valid held high with READ then SET -> second command accepted only when busy = 0; the first command's GAP is fully observed; no Dset = 1 cycle overlaps Dbl = 1111.
- RRAM_VERIFY_EN, SET data = 0011, sum_bit stuck at 0001 -> exactly 4 WR_PULSE bursts (1 + MAX_RETRY); rsp_err = 1, rsp_data = 0001.
- RRAM_VERIFY_EN, sum_bit = 0011 on the first verify -> single pulse burst; rsp_err = 0, rsp_data = 0011.

Source files
------------

// File: rtl/rram_xbar_seq.sv
// rram_xbar_seq: timed command sequencer for a 4x4 RRAM crossbar.
// It produces the registered Dwl/Dsl/Dbl/Dset drives for a SET (program
// row) or an inference READ. It captures the synchronised comparator bits
// and returns a one-cycle response.
// Optional write-verify loop: define RRAM_VERIFY_EN.
module rram_xbar_seq #(
    parameter int PULSE_CYC  = 8,
    parameter int SETTLE_CYC = 4,
    parameter int GAP_CYC    = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [1:0] cmd_row,
    input  logic [3:0] cmd_data,
    output logic [3:0] Dwl,
    output logic [3:0] Dsl,
    output logic [3:0] Dbl,
    output logic       Dset,
    input  logic [3:0] sum_bit,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_BIAS,
        RD_SAMPLE,
`ifdef RRAM_VERIFY_EN
        VFY_BIAS,
        VFY_CHECK,
`endif
        GAP
    } state_t;

    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] row_q;
    logic [3:0] data_q;
    logic [3:0] sync_a, sync_b;

    logic       accept;
    logic [1:0] row_nx;
    logic [3:0] data_nx;
    logic [3:0] dwl_d, dbl_d;
    logic       dset_d;
    logic       rsp_valid_d, rsp_err_d;
    logic [3:0] rsp_data_d;

`ifdef RRAM_VERIFY_EN
    logic [2:0] retry_q, retry_d;
    logic       redo_q, redo_d;
`endif

    assign accept  = cmd_valid && (state_q == IDLE);
    // The drives for the first state of a command are decoded from the
    // command inputs, because the latch is only written on the accept edge.
    assign row_nx  = accept ? cmd_row  : row_q;
    assign data_nx = accept ? cmd_data : data_q;

    // Next-state, cycle counter, response and drive decode.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path that leaves one unassigned would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 4'b0000;
        rsp_err_d   = 1'b0;
`ifdef RRAM_VERIFY_EN
        retry_d     = retry_q;
        redo_d      = redo_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = cmd_op ? WR_SETUP : RD_BIAS;
`ifdef RRAM_VERIFY_EN
                    retry_d = '0;
                    redo_d  = 1'b0;
`endif
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_HOLD: begin
                cnt_d = '0;
`ifdef RRAM_VERIFY_EN
                state_d = VFY_BIAS;
`else
                state_d     = GAP;
                rsp_valid_d = 1'b1;
`endif
            end
            RD_BIAS: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_SAMPLE: begin
                cnt_d       = '0;
                state_d     = GAP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = sync_b;
            end
`ifdef RRAM_VERIFY_EN
            VFY_BIAS: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = VFY_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            VFY_CHECK: begin
                cnt_d   = '0;
                state_d = GAP;
                if (sync_b == data_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sync_b;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    retry_d = retry_q + 3'd1;
                    redo_d  = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sync_b;
                    rsp_err_d   = 1'b1;
                end
            end
`endif
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
`ifdef RRAM_VERIFY_EN
                    state_d = redo_q ? WR_SETUP : IDLE;
                    redo_d  = 1'b0;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // The drives follow the state being entered, so each registered drive lines up with its state.
        dwl_d  = 4'b0000;
        dbl_d  = 4'b0000;
        dset_d = 1'b0;
        case (state_d)
            WR_SETUP, WR_HOLD: begin
                dset_d = 1'b1;
                dbl_d  = data_nx;
            end
            WR_PULSE: begin
                dset_d = 1'b1;
                dbl_d  = data_nx;
                dwl_d  = 4'b0001 << row_nx;
            end
            RD_BIAS, RD_SAMPLE: begin
                dbl_d = 4'b1111;
                dwl_d = data_nx;
            end
`ifdef RRAM_VERIFY_EN
            VFY_BIAS, VFY_CHECK: begin
                dbl_d = 4'b1111;
                dwl_d = 4'b0001 << row_nx;
            end
`endif
            default: begin
                dwl_d  = 4'b0000;
                dbl_d  = 4'b0000;
                dset_d = 1'b0;
            end
        endcase
    end

    // State register, cycle counter and command latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                row_q  <= cmd_row;
                data_q <= cmd_data;
            end
        end
    end

`ifdef RRAM_VERIFY_EN
    // Retry bookkeeping for the write-verify loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
            redo_q  <= 1'b0;
        end else begin
            retry_q <= retry_d;
            redo_q  <= redo_d;
        end
    end
`endif

    // Two-flop synchroniser for the asynchronous comparator outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sum_bit;
            sync_b <= sync_a;
        end
    end

    // Registered outputs. The async clear drops every drive the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dwl       <= '0;
            Dsl       <= '0;
            Dbl       <= '0;
            Dset      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            Dwl       <= dwl_d;
            Dsl       <= 4'b0000;
            Dbl       <= dbl_d;
            Dset      <= dset_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_rram_xbar_seq.sv
// tb_rram_xbar_seq: scoreboard bench for rram_xbar_seq (default parameters).
// The write-verify scenarios build when RRAM_VERIFY_EN is defined.
module tb_rram_xbar_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [1:0] cmd_row = '0;
    logic [3:0] cmd_data = '0;
    logic [3:0] Dwl, Dsl, Dbl;
    logic       Dset;
    logic [3:0] sum_bit = '0;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    typedef struct {
        logic [3:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

`ifdef RRAM_VERIFY_EN
    localparam int SET_LAT = 15;
`else
    localparam int SET_LAT = 10;
`endif
    localparam int READ_LAT = 5;

    rram_xbar_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .Dwl(Dwl), .Dsl(Dsl), .Dbl(Dbl), .Dset(Dset),
        .sum_bit(sum_bit),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Expected SET readback: the programmed pattern with verify, zero without.
    function automatic logic [3:0] set_rsp(input logic [3:0] d);
`ifdef RRAM_VERIFY_EN
        return d;
`else
        return 4'b0000;
`endif
    endfunction

    // Monitor: drive-safety rules every cycle, and responses against the scoreboard.
    initial begin : monitor
        logic [3:0] prev_dwl;
        logic       prev_dset;
        exp_t       e;
        prev_dwl  = '0;
        prev_dset = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_dwl  = '0;
                prev_dset = 1'b0;
            end else begin
                // SET patterns used here are never 1111, so Dset with Dbl=1111 is always a fault.
                checks++;
                if (Dsl !== 4'b0000 || (Dset === 1'b1 && Dbl === 4'b1111) ||
                    (Dset !== prev_dset && prev_dwl !== 4'b0000)) begin
                    errors++;
                    $display("FAIL drive_safety cyc=%0d Dwl=%b Dsl=%b Dbl=%b Dset=%b prevDwl=%b prevDset=%b",
                             cyc, Dwl, Dsl, Dbl, Dset, prev_dwl, prev_dset);
                end
                prev_dwl  = Dwl;
                prev_dset = Dset;
                if (rsp_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected cyc=%0d data=%b err=%b", cyc, rsp_data, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        if (rsp_data !== e.data || rsp_err !== e.err || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL rsp got data=%b err=%b cyc=%0d want data=%b err=%b cyc=%0d",
                                     rsp_data, rsp_err, cyc, e.data, e.err, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic err, input int at);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Offers a command and returns the cycle of the accepting edge; keep leaves cmd_valid high.
    task automatic issue(input logic op, input logic [1:0] row, input logic [3:0] data,
                         input logic keep, output int acc);
        logic rdy;
        int   n;
        cmd_op    = op;
        cmd_row   = row;
        cmd_data  = data;
        cmd_valid = 1'b1;
        acc = -1;
        n   = 0;
        while (acc < 0 && n < 64) begin
            rdy = cmd_ready;
            tick();
            n++;
            if (rdy) acc = cyc;
        end
        if (!keep) cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%b got no accept want accept within 64 cycles", op);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b pending=%0d want busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({Dwl, Dsl, Dbl, Dset, rsp_valid, rsp_data, rsp_err, cmd_ready, busy} !==
            {4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values Dwl=%b Dsl=%b Dbl=%b Dset=%b rv=%b rd=%b re=%b rdy=%b busy=%b want zeros rdy=1",
                     Dwl, Dsl, Dbl, Dset, rsp_valid, rsp_data, rsp_err, cmd_ready, busy);
        end
    endtask

    task automatic test_set();
        int         a;
        logic [8:0] want;
        sum_bit = 4'b1011;
        issue(1'b1, 2'd2, 4'b1011, 1'b0, a);
        push(set_rsp(4'b1011), 1'b0, a + SET_LAT);
`ifdef RRAM_VERIFY_EN
        for (int k = 1; k <= 10; k++) begin
`else
        for (int k = 1; k <= 12; k++) begin
`endif
            if (k == 1 || k == 10) want = {4'b0000, 4'b1011, 1'b1};
            else if (k <= 9)       want = {4'b0100, 4'b1011, 1'b1};
            else                   want = {4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({Dwl, Dbl, Dset} !== want) begin
                errors++;
                $display("FAIL set_trace k=%0d got Dwl=%b Dbl=%b Dset=%b want %b", k, Dwl, Dbl, Dset, want);
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_read(input logic [3:0] wl, input logic [3:0] sb);
        int         a;
        logic [8:0] want;
        sum_bit = sb;
        issue(1'b0, 2'd0, wl, 1'b0, a);
        push(sb, 1'b0, a + READ_LAT);
        for (int k = 1; k <= 8; k++) begin
            want = (k <= 5) ? {wl, 4'b1111, 1'b0} : 9'd0;
            checks++;
            if ({Dwl, Dbl, Dset} !== want || cmd_ready !== (k == 8)) begin
                errors++;
                $display("FAIL read_trace k=%0d got Dwl=%b Dbl=%b Dset=%b rdy=%b want %b rdy=%b",
                         k, Dwl, Dbl, Dset, cmd_ready, want, (k == 8));
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int   a, b, k;
        logic rdy;
        sum_bit = 4'b0010;
        issue(1'b0, 2'd0, 4'b0101, 1'b1, a);
        push(4'b0010, 1'b0, a + READ_LAT);
        cmd_op   = 1'b1;
        cmd_row  = 2'd1;
        cmd_data = 4'b0110;
        b = -1;
        k = 1;
        while (b < 0 && k < 20) begin
            if (k == 6 || k == 7) begin
                checks++;
                if ({Dwl, Dbl, Dset, busy} !== {4'b0, 4'b0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_gap k=%0d got Dwl=%b Dbl=%b Dset=%b busy=%b want drives 0 busy=1",
                             k, Dwl, Dbl, Dset, busy);
                end
            end
            rdy = cmd_ready;
            tick();
            k++;
            if (rdy) b = cyc;
        end
        cmd_valid = 1'b0;
        checks++;
        if (b - a != 8) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles want 8", b - a);
        end
        push(set_rsp(4'b0110), 1'b0, b + SET_LAT);
`ifdef RRAM_VERIFY_EN
        sum_bit = 4'b0110;
`endif
        wait_idle();
    endtask

`ifdef RRAM_VERIFY_EN
    task automatic test_verify(input logic [3:0] d, input logic [3:0] sb,
                               input int want_bursts, input logic want_err, input int lat);
        int         a, bursts, n;
        logic [3:0] last_dwl;
        sum_bit = sb;
        issue(1'b1, 2'd0, d, 1'b0, a);
        push(sb, want_err, a + lat);
        bursts   = (Dwl !== 4'b0000 && Dset === 1'b1) ? 1 : 0;
        last_dwl = Dwl;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
            if (Dwl !== 4'b0000 && last_dwl === 4'b0000 && Dset === 1'b1) bursts++;
            last_dwl = Dwl;
        end
        checks++;
        if (bursts != want_bursts) begin
            errors++;
            $display("FAIL verify_bursts got %0d want %0d", bursts, want_bursts);
        end
        wait_idle();
    endtask
`endif

    task automatic test_reset_mid_pulse();
        int a, c;
        sum_bit = 4'b0000;
        issue(1'b1, 2'd2, 4'b1011, 1'b0, a);
        tick();
        tick();
        checks++;
        if (Dwl !== 4'b0100 || Dset !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_pre got Dwl=%b Dset=%b want 0100 1", Dwl, Dset);
        end
        #2;
        c = cyc;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Dwl, Dbl, Dset, busy} !== 10'd0 || cyc != c) begin
            errors++;
            $display("FAIL async_reset got Dwl=%b Dbl=%b Dset=%b busy=%b edges=%0d want all 0 before edge",
                     Dwl, Dbl, Dset, busy, cyc - c);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready got rdy=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_set();
        test_read(4'b0110, 4'b1001);
        test_read(4'b0000, 4'b0000);
        test_read(4'b1111, 4'b0110);
        test_back_to_back();
`ifdef RRAM_VERIFY_EN
        test_verify(4'b0011, 4'b0001, 4, 1'b1, 66);
        test_verify(4'b0011, 4'b0011, 1, 1'b0, 15);
`endif
        test_reset_mid_pulse();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
